uart_rx: RTL

UART receive path with memory-write DMA. It is the receive-side counterpart of the existing UART transmit block. It deserialises 8N1 frames from the rx pin into an 8-entry byte FIFO, then writes each byte to memory at consecutive addresses from DST_START up to, but not including, DST_STOP. It is configured through the same 2-bit register-select bus the UART uses.

---
 rtl/uart_rx_pkg.sv | 37 +++
 rtl/uart_rx_phy.sv | 165 ++++++++++++++++
 rtl/uart_rx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: register map, CFG bit positions,
// memory access width codes and FSM state encodings.
package uart_rx_pkg;

    localparam logic [1:0] REG_CFG       = 2'b00;
    localparam logic [1:0] REG_DST_START = 2'b01;
    localparam logic [1:0] REG_DST_STOP  = 2'b10;
    localparam logic [1:0] REG_PTR       = 2'b11;

    localparam int CFG_RX_EN      = 1;
    localparam int CFG_RX_DONE    = 3;
    localparam int CFG_OVERRUN    = 4;
    localparam int CFG_FRAME_ERR  = 5;
    localparam int CFG_PARITY_ERR = 6;

    localparam logic [1:0] MEM_ACC_8  = 2'b00;
    localparam logic [1:0] MEM_ACC_16 = 2'b01;
    localparam logic [1:0] MEM_ACC_32 = 2'b10;

    typedef enum logic [2:0] {
        PHY_IDLE   = 3'd0,
        PHY_START  = 3'd1,
        PHY_DATA   = 3'd2,
        PHY_PARITY = 3'd3,
        PHY_STOP   = 3'd4
    } phy_state_e;

    typedef enum logic {
        DMA_IDLE = 1'b0,
        DMA_WAIT = 1'b1
    } dma_state_e;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_phy.sv
// Serial frame receiver: 2-flop synchroniser, baud counter and frame FSM.
// With UART_RX_PARITY_EN defined, frames are 8E1 and a parity error output exists.
module uart_rx_phy
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] rx_byte_o,
    output logic       byte_valid_o,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err_o,
`endif
    output logic       frame_err_o
);

    localparam int            CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
`ifdef UART_RX_PARITY_EN
    localparam phy_state_e    AFTER_DATA = PHY_PARITY;
`else
    localparam phy_state_e    AFTER_DATA = PHY_STOP;
`endif

    logic          sync1_q, sync2_q;
    phy_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          wait_hi_q, wait_hi_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          tc_s;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_q, par_bad_d;
    logic          perr_q, perr_d;
`endif

    assign tc_s = (cnt_q == '0);

    // Frame FSM next-state and event decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        wait_hi_d = wait_hi_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            PHY_IDLE: begin
                if (!sync2_q) begin
                    state_d = PHY_START;
                    cnt_d   = CNT_HALF;
                end else begin
                    state_d = PHY_IDLE;
                end
            end
            PHY_START: begin
                if (!tc_s) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (!sync2_q) begin
                    state_d = PHY_DATA;
                    cnt_d   = CNT_FULL;
                    bit_d   = 3'd0;
                end else begin
                    state_d = PHY_IDLE;
                end
            end
            PHY_DATA: begin
                if (tc_s) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = CNT_FULL;
                    bit_d   = bit_q + 3'd1;
                    state_d = (bit_q == 3'd7) ? AFTER_DATA : PHY_DATA;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            PHY_PARITY: begin
                if (tc_s) begin
                    par_bad_d = sync2_q ^ even_parity(shift_q);
                    cnt_d     = CNT_FULL;
                    state_d   = PHY_STOP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`endif
            PHY_STOP: begin
                // After a low stop bit, hold here until the line is released
                if (wait_hi_q) begin
                    wait_hi_d = !sync2_q;
                    state_d   = sync2_q ? PHY_IDLE : PHY_STOP;
                end else if (!tc_s) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (sync2_q) begin
`ifdef UART_RX_PARITY_EN
                    valid_d = !par_bad_q;
                    perr_d  = par_bad_q;
`else
                    valid_d = 1'b1;
`endif
                    state_d = PHY_IDLE;
                end else begin
                    ferr_d    = 1'b1;
                    wait_hi_d = 1'b1;
                end
            end
            default: begin
                state_d = PHY_IDLE;
            end
        endcase
    end

    // Synchroniser and frame state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= PHY_IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            wait_hi_q <= 1'b0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            sync1_q   <= rx_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            wait_hi_q <= wait_hi_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign rx_byte_o    = shift_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = perr_q;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receive path: serial PHY into a byte FIFO, drained by a write DMA into
// [DST_START, DST_STOP). Optional 8E1 framing with UART_RX_PARITY_EN.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int M_WIDTH         = 32,
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reg_req,
    input  logic               reg_we,
    input  logic [1:0]         reg_select,
    input  logic [M_WIDTH-1:0] reg_data_in,
    output logic [M_WIDTH-1:0] reg_data_out,
    output logic               reg_ready,
    output logic               rx_mem_req,
    input  logic               rx_mem_ready,
    output logic [M_WIDTH-1:0] rx_mem_addr,
    output logic [M_WIDTH-1:0] rx_mem_data_out,
    output logic [1:0]         rx_mem_width,
    input  logic               rx
);

    localparam int                 CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int                 PW           = $clog2(FIFO_DEPTH);
    localparam logic [M_WIDTH-1:0] PTR_ONE      = M_WIDTH'(1);
    localparam logic [PW:0]        FPTR_ONE     = (PW + 1)'(1);

    logic [7:0] phy_byte_s;
    logic       phy_valid_s, phy_ferr_s;

    logic [7:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PW:0]  wr_ptr_q, rd_ptr_q;
    logic         fifo_empty_s, fifo_full_s, push_s, pop_s, overrun_set_s;

    dma_state_e         dma_q, dma_d;
    logic [7:0]         mem_data_q, mem_data_d;
    logic               rx_en_q, rx_en_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic [M_WIDTH-1:0] dst_start_q, dst_start_d, dst_stop_q, dst_stop_d, ptr_q, ptr_d;
    logic [M_WIDTH-1:0] rdata_q, rdata_d, cfg_rd_s;
    logic               ready_q, rx_done_s;
`ifdef UART_RX_PARITY_EN
    logic               phy_perr_s, parity_err_q, parity_err_d;
`endif

    uart_rx_phy #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_phy (
        .clk_i       (clk),
        .rst_ni      (rst),
        .rx_i        (rx),
        .rx_byte_o   (phy_byte_s),
        .byte_valid_o(phy_valid_s),
`ifdef UART_RX_PARITY_EN
        .parity_err_o(phy_perr_s),
`endif
        .frame_err_o (phy_ferr_s)
    );

    assign fifo_empty_s  = (wr_ptr_q == rd_ptr_q);
    assign fifo_full_s   = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign push_s        = phy_valid_s && (!fifo_full_s || pop_s);
    assign overrun_set_s = phy_valid_s && fifo_full_s && !pop_s;
    assign rx_done_s     = (ptr_q == dst_stop_q);

    // CFG read view
    always_comb begin
        cfg_rd_s              = '0;
        cfg_rd_s[CFG_RX_EN]   = rx_en_q;
        cfg_rd_s[CFG_RX_DONE] = rx_done_s;
        cfg_rd_s[CFG_OVERRUN] = overrun_q;
        cfg_rd_s[CFG_FRAME_ERR] = frame_err_q;
`ifdef UART_RX_PARITY_EN
        cfg_rd_s[CFG_PARITY_ERR] = parity_err_q;
`endif
    end

    // DMA FSM; the head byte is captured on entry so it stays stable through WAIT
    always_comb begin
        dma_d      = dma_q;
        mem_data_d = mem_data_q;
        pop_s      = 1'b0;
        case (dma_q)
            DMA_IDLE: begin
                if (rx_en_q && !fifo_empty_s && !rx_done_s) begin
                    dma_d      = DMA_WAIT;
                    mem_data_d = fifo_mem_q[rd_ptr_q[PW-1:0]];
                end else begin
                    dma_d = DMA_IDLE;
                end
            end
            DMA_WAIT: begin
                if (rx_mem_ready) begin
                    pop_s = 1'b1;
                    dma_d = DMA_IDLE;
                end else begin
                    dma_d = DMA_WAIT;
                end
            end
            default: begin
                dma_d = DMA_IDLE;
            end
        endcase
    end

    // Register file; sticky flags favour a new event over a same-cycle clear
    always_comb begin
        rx_en_d     = rx_en_q;
        overrun_d   = overrun_q || overrun_set_s;
        frame_err_d = frame_err_q || phy_ferr_s;
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_err_q || phy_perr_s;
`endif
        dst_start_d = dst_start_q;
        dst_stop_d  = dst_stop_q;
        ptr_d       = pop_s ? (ptr_q + PTR_ONE) : ptr_q;
        rdata_d     = rdata_q;
        if (reg_req) begin
            case (reg_select)
                REG_CFG:       rdata_d = cfg_rd_s;
                REG_DST_START: rdata_d = dst_start_q;
                REG_DST_STOP:  rdata_d = dst_stop_q;
                REG_PTR:       rdata_d = ptr_q;
                default:       rdata_d = '0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
        if (reg_req && reg_we) begin
            case (reg_select)
                REG_CFG: begin
                    rx_en_d     = reg_data_in[CFG_RX_EN];
                    overrun_d   = (overrun_q && !reg_data_in[CFG_OVERRUN]) || overrun_set_s;
                    frame_err_d = (frame_err_q && !reg_data_in[CFG_FRAME_ERR]) || phy_ferr_s;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = (parity_err_q && !reg_data_in[CFG_PARITY_ERR]) || phy_perr_s;
`endif
                end
                REG_DST_START: begin
                    dst_start_d = reg_data_in;
                    ptr_d       = reg_data_in;
                end
                REG_DST_STOP: dst_stop_d = reg_data_in;
                default:      rx_en_d = rx_en_q;
            endcase
        end else begin
            rx_en_d = rx_en_q;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q[PW-1:0]] <= phy_byte_s;
        end
    end

    // Control and register state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            dma_q       <= DMA_IDLE;
            mem_data_q  <= 8'd0;
            rx_en_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            dst_start_q <= '0;
            dst_stop_q  <= '0;
            ptr_q       <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= push_s ? (wr_ptr_q + FPTR_ONE) : wr_ptr_q;
            rd_ptr_q    <= pop_s ? (rd_ptr_q + FPTR_ONE) : rd_ptr_q;
            dma_q       <= dma_d;
            mem_data_q  <= mem_data_d;
            rx_en_q     <= rx_en_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
            dst_start_q <= dst_start_d;
            dst_stop_q  <= dst_stop_d;
            ptr_q       <= ptr_d;
            rdata_q     <= rdata_d;
            ready_q     <= reg_req;
        end
    end

    assign reg_data_out    = rdata_q;
    assign reg_ready       = ready_q;
    assign rx_mem_req      = (dma_q == DMA_WAIT);
    assign rx_mem_addr     = ptr_q;
    assign rx_mem_data_out = {{(M_WIDTH-8){1'b0}}, mem_data_q};
    assign rx_mem_width    = MEM_ACC_8;

endmodule
